// File: rtl/riscv_mem_pkg.sv
// riscv_pkg: shared definitions for the RISC-V memory-access stage.
// Holds funct3 load/store codes, the stage FSM state enum and width defaults.
// Also has helpers that classify access size and detect misalignment.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGN_DEF = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Any funct3 outside the listed byte/half codes is handled as a word access.
  function automatic acc_size_e acc_size(input logic [2:0] f3, input logic is_load);
    acc_size_e sz;
    sz = SZ_WORD;
    if (f3 == F3_LB || (is_load && f3 == F3_LBU))      sz = SZ_BYTE;
    else if (f3 == F3_LH || (is_load && f3 == F3_LHU)) sz = SZ_HALF;
    return sz;
  endfunction

  function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (sz == SZ_HALF)      mis = off[0];
    else if (sz == SZ_WORD) mis = (off != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/riscv_mem_if.sv
// riscv_mem_if: execute-side handshake, data-memory bus and writeback outputs.
// slave is the memory stage; master is the surrounding pipeline / memory.
// Data width is fixed at 32 bits; REGA is the register index width.
interface riscv_mem_if #(
  parameter int XLEN = 32,
  parameter int REGA = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   ex_result;
  logic [XLEN-1:0]   st_data;
  logic              is_load;
  logic              is_store;
  logic [2:0]        funct3;
  logic [REGA-1:0]   rd_in;

  logic              dmem_req;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_be;
  logic              dmem_ack;
  logic [XLEN-1:0]   dmem_rdata;

  logic [XLEN-1:0]   exdata;
  logic [XLEN-1:0]   memdata;
  logic              memfetch;
  logic [REGA-1:0]   rd;
  logic              misaligned;

  modport slave (
    input  in_valid, ex_result, st_data, is_load, is_store, funct3, rd_in,
    input  dmem_ack, dmem_rdata,
    output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output exdata, memdata, memfetch, rd, misaligned
  );

  modport master (
    output in_valid, ex_result, st_data, is_load, is_store, funct3, rd_in,
    output dmem_ack, dmem_rdata,
    input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  exdata, memdata, memfetch, rd, misaligned
  );
endinterface

// File: rtl/riscv_mem_align.sv
// riscv_mem_align: store data replication / byte-enable generation and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; the parent stage decides when results are used.
module riscv_mem_align
  import riscv_pkg::*;
(
  input  acc_size_e   st_sz_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  input  acc_size_e   ld_sz_i,
  input  logic        ld_sgn_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the lane and enable only the addressed bytes
  always_comb begin
    wdata_o = st_data_i;
    be_o    = 4'b1111;
    case (st_sz_i)
      SZ_BYTE: begin
        wdata_o = {4{st_data_i[7:0]}};
        be_o    = 4'b0001 << st_off_i;
      end
      SZ_HALF: begin
        wdata_o = {2{st_data_i[15:0]}};
        be_o    = 4'b0011 << {st_off_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane (halfwords ignore off[0]) and extend
  always_comb begin
    ld_byte = rdata_i[{ld_off_i, 3'b000} +: 8];
    ld_half = rdata_i[{ld_off_i[1], 4'b0000} +: 16];
    ldata_o = rdata_i;
    case (ld_sz_i)
      SZ_BYTE: ldata_o = {{24{ld_sgn_i & ld_byte[7]}}, ld_byte};
      SZ_HALF: ldata_o = {{16{ld_sgn_i & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_mem.sv
// riscv_mem: memory-access stage; optional trap on misaligned access via RISCV_MISALIGN_TRAP_EN.
// Latency: 1 cycle for non-memory ops; memory ops retire the cycle after dmem_ack (2 minimum).
// Backpressure: in_ready is low for the whole WAIT state; one outstanding dmem request.
module riscv_mem
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGN = REGN_DEF,
  parameter int REGA = $clog2(REGN)
) (
  input logic      clk,
  input logic      rst,
  riscv_mem_if.slave bus
);

`ifdef RISCV_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  mem_state_e        state_q;
  logic              req_q, we_q, load_q, memfetch_q, mis_q;
  logic [XLEN-1:0]   addr_q, wdata_q, exdata_q, memdata_q;
  logic [XLEN/8-1:0] be_q;
  logic [REGA-1:0]   rd_q, rd_pend_q;
  logic [1:0]        off_q;
  acc_size_e         ld_sz_q;
  logic              ld_sgn_q;

  logic              accept, is_mem, trap_d;
  logic [1:0]        off_d;
  acc_size_e         sz_d;
  logic [XLEN-1:0]   st_wdata_d, ld_data_d;
  logic [XLEN/8-1:0] st_be_d;

  assign accept = bus.in_valid && (state_q == IDLE);
  assign is_mem = bus.is_load || bus.is_store;
  assign off_d  = bus.ex_result[1:0];
  assign sz_d   = acc_size(bus.funct3, bus.is_load);
  assign trap_d = TRAP_EN && is_mem && is_misaligned(sz_d, off_d);

  riscv_mem_align u_align (
    .st_sz_i   (sz_d),
    .st_off_i  (off_d),
    .st_data_i (bus.st_data),
    .wdata_o   (st_wdata_d),
    .be_o      (st_be_d),
    .ld_sz_i   (ld_sz_q),
    .ld_sgn_i  (ld_sgn_q),
    .ld_off_i  (off_q),
    .rdata_i   (bus.dmem_rdata),
    .ldata_o   (ld_data_d)
  );

  // Stage FSM: issue the request, hold it until ack, register writeback outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      exdata_q   <= '0;
      memdata_q  <= '0;
      memfetch_q <= 1'b0;
      rd_q       <= '0;
      mis_q      <= 1'b0;
      rd_pend_q  <= '0;
      off_q      <= 2'b00;
      ld_sz_q    <= SZ_WORD;
      ld_sgn_q   <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      rd_q       <= '0;
      memfetch_q <= 1'b0;
      mis_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (trap_d) begin
              mis_q <= 1'b1;
            end else if (is_mem) begin
              req_q     <= 1'b1;
              we_q      <= bus.is_store;
              addr_q    <= {bus.ex_result[XLEN-1:2], 2'b00};
              wdata_q   <= st_wdata_d;
              be_q      <= st_be_d;
              off_q     <= off_d;
              ld_sz_q   <= sz_d;
              ld_sgn_q  <= ~bus.funct3[2];
              load_q    <= bus.is_load;
              rd_pend_q <= bus.rd_in;
              state_q   <= WAIT;
            end else begin
              exdata_q <= bus.ex_result;
              rd_q     <= bus.rd_in;
            end
          end
        end
        WAIT: begin
          if (bus.dmem_ack) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            if (load_q) begin
              memfetch_q <= 1'b1;
              rd_q       <= rd_pend_q;
              memdata_q  <= ld_data_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_be    = be_q;
  assign bus.exdata     = exdata_q;
  assign bus.memdata    = memdata_q;
  assign bus.memfetch   = memfetch_q;
  assign bus.rd         = rd_q;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_riscv_mem.sv
// tb_riscv_mem: directed vectors for the memory stage with a queue-based scoreboard.
// Stimulus pushes expected requests and retirements; a negedge monitor pops and compares.
// Misaligned-trap expectations follow RISCV_MISALIGN_TRAP_EN.
module tb_riscv_mem;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_mem_if #(.XLEN(32), .REGA(5)) bus ();
  riscv_mem #(.XLEN(32), .REGN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] data;
    logic        memfetch;
    logic [4:0]  rd;
  } wb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic        chk_data;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  wb_t  exp_wb[$];
  req_t exp_req[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wb_cyc = 0;
  int   acc_cyc = 0;
  int   mis_seen = 0;
  logic prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%08h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Monitor: compare each new dmem request and each retirement against the queues
  always @(negedge clk) begin
    req_t re;
    wb_t  we;
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (bus.misaligned) mis_seen++;
      if (bus.dmem_req && !prev_req) begin
        if (exp_req.size() == 0) fail_now("unexpected_req", bus.dmem_addr);
        else begin
          re = exp_req.pop_front();
          chk("req_addr", bus.dmem_addr, re.addr);
          chk("req_we", {31'b0, bus.dmem_we}, {31'b0, re.we});
          if (re.chk_data) begin
            chk("req_wdata", bus.dmem_wdata, re.wdata);
            chk("req_be", {28'b0, bus.dmem_be}, {28'b0, re.be});
          end
        end
      end
      prev_req = bus.dmem_req;
      if (bus.rd != 5'd0 || bus.memfetch) begin
        wb_cyc = cyc;
        if (exp_wb.size() == 0) fail_now("unexpected_retire", {27'b0, bus.rd});
        else begin
          we = exp_wb.pop_front();
          chk("wb_rd", {27'b0, bus.rd}, {27'b0, we.rd});
          chk("wb_memfetch", {31'b0, bus.memfetch}, {31'b0, we.memfetch});
          chk(we.memfetch ? "wb_memdata" : "wb_exdata",
              we.memfetch ? bus.memdata : bus.exdata, we.data);
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present one execute result; returns just after the accepting edge
  task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rdi);
    bus.in_valid  = 1'b1;
    bus.is_load   = ld;
    bus.is_store  = st;
    bus.funct3    = f3;
    bus.ex_result = addr;
    bus.st_data   = sdata;
    bus.rd_in     = rdi;
    acc_cyc       = cyc;
    sync();
    bus.in_valid = 1'b0;
    bus.is_load  = 1'b0;
    bus.is_store = 1'b0;
  endtask

  // Memory model: wait for the request, stall nwait cycles, then ack for one cycle
  task automatic respond(input int nwait, input logic [31:0] rdata);
    int n = 0;
    while (!bus.dmem_req && n < 50) begin
      sync();
      n++;
    end
    if (!bus.dmem_req) begin
      fail_now("req_timeout", 32'(n));
    end else begin
      for (int i = 0; i < nwait; i++) begin
        chk("in_ready_in_wait", {31'b0, bus.in_ready}, 32'd0);
        sync();
      end
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = rdata;
      sync();
      bus.dmem_ack = 1'b0;
    end
  endtask

  task automatic push_wb(input logic [31:0] d, input logic mf, input logic [4:0] r);
    wb_t w;
    w.data = d; w.memfetch = mf; w.rd = r;
    exp_wb.push_back(w);
  endtask

  task automatic push_req(input logic [31:0] a, input logic w, input logic cd,
                          input logic [31:0] wd, input logic [3:0] b);
    req_t q;
    q.addr = a; q.we = w; q.chk_data = cd; q.wdata = wd; q.be = b;
    exp_req.push_back(q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0;
    bus.funct3 = 3'b000; bus.ex_result = '0; bus.st_data = '0; bus.rd_in = '0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

    // Reset state
    #12;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_rd", {27'b0, bus.rd}, 32'd0);
    chk("rst_memfetch", {31'b0, bus.memfetch}, 32'd0);
    chk("rst_exdata", bus.exdata, 32'd0);
    chk("rst_memdata", bus.memdata, 32'd0);
    chk("rst_dmem_addr", bus.dmem_addr, 32'd0);
    chk("rst_misaligned", {31'b0, bus.misaligned}, 32'd0);
    sync();
    rst = 1'b0;
    sync();

    // Non-memory op: one-cycle latency, bubble afterwards, exdata held
    push_wb(32'h1234_5678, 1'b0, 5'd5);
    send(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
    @(negedge clk); #1;
    chk("nonmem_latency", 32'(wb_cyc - acc_cyc), 32'd1);
    @(negedge clk); #1;
    chk("bubble_rd", {27'b0, bus.rd}, 32'd0);
    chk("bubble_memfetch", {31'b0, bus.memfetch}, 32'd0);
    chk("exdata_hold", bus.exdata, 32'h1234_5678);
    sync();

    // LB 0x103 with three wait cycles: top byte 0x80 sign-extended
    push_req(32'h100, 1'b0, 1'b0, 32'h0, 4'h0);
    push_wb(32'hFFFF_FF80, 1'b1, 5'd3);
    send(1'b1, 1'b0, F3_LB, 32'h103, 32'h0, 5'd3);
    respond(3, 32'h80FF_0011);
    @(negedge clk); #1;
    chk("lb_latency", 32'(wb_cyc - acc_cyc), 32'd5);
    sync();

    // LHU 0x102 with immediate ack: minimum latency 2
    push_req(32'h100, 1'b0, 1'b0, 32'h0, 4'h0);
    push_wb(32'h0000_BEEF, 1'b1, 5'd4);
    send(1'b1, 1'b0, F3_LHU, 32'h102, 32'h0, 5'd4);
    respond(0, 32'hBEEF_1234);
    @(negedge clk); #1;
    chk("lhu_latency", 32'(wb_cyc - acc_cyc), 32'd2);
    sync();

    // SB 0x202, then a non-memory op accepted in the cycle right after ack
    push_req(32'h200, 1'b1, 1'b1, 32'hABAB_ABAB, 4'b0100);
    send(1'b0, 1'b1, F3_SB, 32'h202, 32'h0000_00AB, 5'd7);
    respond(1, 32'h0);
    chk("store_retire_rd", {27'b0, bus.rd}, 32'd0);
    chk("store_retire_memfetch", {31'b0, bus.memfetch}, 32'd0);
    chk("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
    push_wb(32'hCAFE_F00D, 1'b0, 5'd9);
    send(1'b0, 1'b0, 3'b000, 32'hCAFE_F00D, 32'h0, 5'd9);
    sync();

    // LH sign-extend, SH upper half, SW, LBU middle byte
    push_req(32'h000, 1'b0, 1'b0, 32'h0, 4'h0);
    push_wb(32'hFFFF_8001, 1'b1, 5'd10);
    send(1'b1, 1'b0, F3_LH, 32'h000, 32'h0, 5'd10);
    respond(2, 32'h0000_8001);
    sync();
    push_req(32'h304, 1'b1, 1'b1, 32'hCAFE_CAFE, 4'b1100);
    send(1'b0, 1'b1, F3_SH, 32'h306, 32'h1234_CAFE, 5'd11);
    respond(0, 32'h0);
    sync();
    push_req(32'h40C, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'b1111);
    send(1'b0, 1'b1, F3_SW, 32'h40C, 32'hDEAD_BEEF, 5'd12);
    respond(0, 32'h0);
    sync();
    push_req(32'h000, 1'b0, 1'b0, 32'h0, 4'h0);
    push_wb(32'h0000_00A5, 1'b1, 5'd13);
    send(1'b1, 1'b0, F3_LBU, 32'h001, 32'h0, 5'd13);
    respond(1, 32'h0000_A500);
    sync();

    // LW at 0x101: trapped when the feature is on, otherwise issued word-aligned
`ifdef RISCV_MISALIGN_TRAP_EN
    send(1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 5'd14);
    chk("mis_pulse", {31'b0, bus.misaligned}, 32'd1);
    chk("mis_rd", {27'b0, bus.rd}, 32'd0);
    chk("mis_no_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("mis_in_ready", {31'b0, bus.in_ready}, 32'd1);
    sync();
    chk("mis_pulse_end", {31'b0, bus.misaligned}, 32'd0);
    chk("mis_no_req_later", {31'b0, bus.dmem_req}, 32'd0);
`else
    push_req(32'h100, 1'b0, 1'b0, 32'h0, 4'h0);
    push_wb(32'h1122_3344, 1'b1, 5'd14);
    send(1'b1, 1'b0, F3_LW, 32'h101, 32'h0, 5'd14);
    respond(0, 32'h1122_3344);
`endif
    sync();

    // Reset during WAIT abandons the request; a late ack retires nothing
    push_req(32'h400, 1'b0, 1'b0, 32'h0, 4'h0);
    send(1'b1, 1'b0, F3_LW, 32'h400, 32'h0, 5'd15);
    sync();
    rst = 1'b1;
    #1;
    chk("rst_wait_req_drop", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_wait_in_ready", {31'b0, bus.in_ready}, 32'd1);
    sync();
    rst = 1'b0;
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h5555_AAAA;
    sync();
    bus.dmem_ack = 1'b0;
    chk("late_ack_rd", {27'b0, bus.rd}, 32'd0);
    chk("late_ack_memfetch", {31'b0, bus.memfetch}, 32'd0);
    chk("late_ack_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("late_ack_in_ready", {31'b0, bus.in_ready}, 32'd1);
    sync();
    sync();

    chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
    chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
`ifdef RISCV_MISALIGN_TRAP_EN
    chk("mis_count", 32'(mis_seen), 32'd1);
`else
    chk("mis_count", 32'(mis_seen), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_mem.md
# riscv_mem

Memory-access stage of the RISC-V pipeline, sitting between execute and writeback. It accepts one execute result per handshake and performs loads and stores over a single-outstanding data-memory request/ack interface. Loads are aligned and sign/zero-extended. Results are presented to writeback as `exdata`/`memdata`/`memfetch`/`rd`, with `rd = 0` marking a bubble.

## Interface
Parameters:
- `XLEN`, 32, data/address width; must be 32.
- `REGN`, 32, register count.
- `REGA`, `$clog2(REGN)`, register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: execute result valid.
- `in_ready` out 1: stage can accept.
- `ex_result` in XLEN: ALU result, or effective address for load/store.
- `st_data` in XLEN: rs2 value for stores.
- `is_load` in 1, `is_store` in 1: never both high.
- `funct3` in 3: access width and sign.
- `rd_in` in REGA: destination register.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out XLEN (word-aligned), `dmem_wdata` out XLEN, `dmem_be` out XLEN/8.
- `dmem_ack` in 1, `dmem_rdata` in XLEN.
- `exdata` out XLEN, `memdata` out XLEN, `memfetch` out 1, `rd` out REGA: to writeback.
- `misaligned` out 1: one-cycle pulse (see Configuration).

## Operation
- FSM states: IDLE, WAIT.
- `in_ready = (state == IDLE)`. Accept = `in_valid && in_ready`.
- IDLE, non-memory op accepted:
  - Next cycle: `exdata = ex_result`, `rd = rd_in`, `memfetch = 0`.
  - Stay in IDLE.
- IDLE, load or store accepted:
  - Register `dmem_addr = {ex_result[31:2], 2'b00}`, `dmem_we = is_store`, `dmem_wdata`, `dmem_be`.
  - Assert `dmem_req` and go to WAIT.
- WAIT:
  - `dmem_req` and all `dmem_*` outputs are held stable until `dmem_ack`.
  - On `dmem_ack`: deassert `dmem_req` and return to IDLE.
  - Load retire (next cycle): `memfetch = 1`, `rd = rd_in`, `memdata` = aligned data.
  - Store retire: `rd = 0`, `memfetch = 0`.
- Any cycle with no retirement: `rd = 0`, `memfetch = 0`. `exdata` and `memdata` hold their previous values.
- Store encoding, with `off = ex_result[1:0]`:
  - SB (000): `wdata = {4{st_data[7:0]}}`, `be = 4'b0001 << off`.
  - SH (001): `wdata = {2{st_data[15:0]}}`, `be = 4'b0011 << {off[1],1'b0}`.
  - SW (010): `wdata = st_data`, `be = 4'b1111`.
- Load extract: select byte/half from `dmem_rdata` by latched `off`.
  - LB 000 and LH 001 sign-extend.
  - LBU 100 and LHU 101 zero-extend.
  - LW 010 passes through.
- Unlisted `funct3` on load/store: treated as word access.
- `dmem_ack` is ignored in IDLE.

## Timing
- Reset: state IDLE; `in_ready = 1` (combinational from state); all other outputs 0.
- Non-memory latency: 1 cycle from accept to writeback outputs.
- Memory op latency: accept at cycle T, `dmem_req` high from T+1, ack at cycle A ≥ T+1, writeback outputs at A+1. Minimum is 2 cycles.
- Back-to-back: new accept is possible in the cycle after ack; ack-cycle retirement and the next accept never overlap.
- Reset mid-WAIT: request is abandoned, `dmem_req` drops asynchronously, nothing retires.

## Configuration
- `RISCV_MISALIGN_TRAP_EN` defined:
  - Misaligned access is LH/LHU/SH with `off[0]`, or LW/SW with `off != 0`.
  - It issues no `dmem_req`; `misaligned` pulses 1 cycle after accept with `rd = 0`; state stays IDLE.
- Undefined:
  - `misaligned` is tied 0.
  - Halfword ops ignore `off[0]`; word ops ignore `off`; the access is always issued.

## Structure
- Shared package `riscv_pkg`:
  - `funct3` load/store codes (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`, `F3_SB`, `F3_SH`, `F3_SW`).
  - Memory-stage state enum.
  - XLEN/REGN defaults.
- Sub-module `riscv_mem_align`: purely combinational load extract/extend and store replicate/byte-enable generation; instantiated once.

## Test plan
- Non-memory op, `ex_result = 0x1234_5678`, `rd_in = 5` → next cycle `exdata = 0x12345678`, `rd = 5`, `memfetch = 0`; following idle cycle `rd = 0`.
- LB, addr `0x103`, `rdata = 0x80FF_0011`, ack after 3 wait cycles → `dmem_addr = 0x100`, `memdata = 0xFFFFFF80`, `memfetch = 1`; `in_ready = 0` throughout WAIT.
- LHU, addr `0x102`, `rdata = 0xBEEF_1234`, immediate ack → `memdata = 0x0000BEEF`, total latency 2.
- SB, addr `0x202`, `st_data = 0xAB` → `be = 4'b0100`, `wdata = 0xABABABAB`, `we = 1`; retire with `rd = 0`.
- `rst` asserted during WAIT, then late `dmem_ack` → `dmem_req = 0`, no retirement, state IDLE.
- With `RISCV_MISALIGN_TRAP_EN`, LW addr `0x101` → no `dmem_req`, `misaligned` pulses once, `rd = 0`.
